// File: rtl/screen_seq_ctrl.sv
// Screen sequencer for the puzzle game display path.
// Runs start/level-select -> fade-in -> play -> win -> next level (or fade-out
// back to start). Visible outputs only change on the vsync falling edge.
//
// Ports:
//   pixelclk   pixel clock
//   reset_n    asynchronous active-low reset
//   i_vsync    high during visible frame, low during vertical blanking
//   btn_up     level-select up (debounced level)
//   btn_down   level-select down (debounced level)
//   btn_ok     confirm / skip win screen (debounced level)
//   btn_back   abort play (debounced level)
//   win_i      one-cycle pulse from game logic: level cleared
//   level      level index for the renderers (frame-synchronised)
//   scr_sel    screen code: 0 START, 1 GAME, 2 WIN, 3 BLANK (frame-synchronised)
//   game_rst   one-cycle pulse reloading the game map on entry to play
//   busy       high while fading in or out (combinational from state)
module screen_seq_ctrl #(
    parameter int unsigned LEVELS      = 3,
    parameter int unsigned HOLD_FRAMES = 30,
    parameter int unsigned WIN_FRAMES  = 120
) (
    input  logic       pixelclk,
    input  logic       reset_n,
    input  logic       i_vsync,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_ok,
    input  logic       btn_back,
    input  logic       win_i,
    output logic [1:0] level,
    output logic [1:0] scr_sel,
    output logic       game_rst,
    output logic       busy
);

    localparam int unsigned MAX_FRAMES = (HOLD_FRAMES > WIN_FRAMES) ? HOLD_FRAMES : WIN_FRAMES;
    localparam int unsigned CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

    localparam logic [1:0]       LAST_LEVEL = 2'(LEVELS - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_FRAMES - 1);
    localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(WIN_FRAMES - 1);

    localparam logic [1:0] SCR_START = 2'd0;
    localparam logic [1:0] SCR_GAME  = 2'd1;
    localparam logic [1:0] SCR_WIN   = 2'd2;
    localparam logic [1:0] SCR_BLANK = 2'd3;

    typedef enum logic [2:0] {
        ST_START,
        ST_FADE_IN,
        ST_PLAY,
        ST_WIN,
        ST_FADE_OUT
    } state_t;

    state_t           state, state_next;
    logic [1:0]       sel_level, sel_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             game_rst_next;
    logic [1:0]       scr_code;

    logic vsync_d, up_d, down_d, ok_d, back_d;
    logic frame_start, up_ev, down_ev, ok_ev, back_ev;

    // Edge detection against one-cycle delayed copies
    assign frame_start = vsync_d & ~i_vsync;
    assign up_ev       = btn_up   & ~up_d;
    assign down_ev     = btn_down & ~down_d;
    assign ok_ev       = btn_ok   & ~ok_d;
    assign back_ev     = btn_back & ~back_d;

    assign busy = (state == ST_FADE_IN) || (state == ST_FADE_OUT);

    // State, level and counter registers; outputs load only at frame start
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_START;
            sel_level <= 2'd0;
            cnt       <= '0;
            game_rst  <= 1'b0;
            level     <= 2'd0;
            scr_sel   <= SCR_START;
            vsync_d   <= 1'b0;
            up_d      <= 1'b0;
            down_d    <= 1'b0;
            ok_d      <= 1'b0;
            back_d    <= 1'b0;
        end else begin
            state     <= state_next;
            sel_level <= sel_next;
            cnt       <= cnt_next;
            game_rst  <= game_rst_next;
            vsync_d   <= i_vsync;
            up_d      <= btn_up;
            down_d    <= btn_down;
            ok_d      <= btn_ok;
            back_d    <= btn_back;
            if (frame_start) begin
                scr_sel <= scr_code;
                level   <= sel_level;
            end
        end
    end

    // Next-state, level-select and frame counting
    always_comb begin
        state_next    = state;
        sel_next      = sel_level;
        cnt_next      = cnt;
        game_rst_next = 1'b0;
        scr_code      = SCR_START;

        unique case (state)
            ST_START: begin
                scr_code = SCR_START;
                if (ok_ev) begin
                    state_next = ST_FADE_IN;
                    cnt_next   = '0;
                end else if (up_ev && !down_ev) begin
                    sel_next = (sel_level == LAST_LEVEL) ? 2'd0 : sel_level + 2'd1;
                end else if (down_ev && !up_ev) begin
                    sel_next = (sel_level == 2'd0) ? LAST_LEVEL : sel_level - 2'd1;
                end
            end
            ST_FADE_IN: begin
                scr_code = SCR_BLANK;
                if (frame_start) begin
                    if (cnt == HOLD_LAST) begin
                        state_next    = ST_PLAY;
                        cnt_next      = '0;
                        game_rst_next = 1'b1;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            ST_PLAY: begin
                scr_code = SCR_GAME;
                // A clear reported together with back still counts as a win
                if (win_i) begin
                    state_next = ST_WIN;
                    cnt_next   = '0;
                end else if (back_ev) begin
                    state_next = ST_FADE_OUT;
                    cnt_next   = '0;
                end
            end
            ST_WIN: begin
                scr_code = SCR_WIN;
                if (ok_ev || (frame_start && cnt == WIN_LAST)) begin
                    cnt_next = '0;
                    if (sel_level < LAST_LEVEL) begin
                        sel_next   = sel_level + 2'd1;
                        state_next = ST_FADE_IN;
                    end else begin
                        sel_next   = 2'd0;
                        state_next = ST_FADE_OUT;
                    end
                end else if (frame_start) begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_FADE_OUT: begin
                scr_code = SCR_BLANK;
                if (frame_start) begin
                    if (cnt == HOLD_LAST) begin
                        state_next = ST_START;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_START;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_screen_seq_ctrl.sv
// Testbench for screen_seq_ctrl: directed flows plus random button activity,
// every cycle compared against a frame-countdown reference model.
module tb_screen_seq_ctrl;

    localparam int unsigned LEVELS      = 3;
    localparam int unsigned HOLD_FRAMES = 30;
    localparam int unsigned WIN_FRAMES  = 120;
    localparam int unsigned FRAME_CYC   = 10;
    localparam int unsigned VIS_CYC     = 7;

    logic       pixelclk = 1'b0;
    logic       reset_n  = 1'b0;
    logic       i_vsync  = 1'b1;
    logic       btn_up   = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_ok   = 1'b0;
    logic       btn_back = 1'b0;
    logic       win_i    = 1'b0;
    logic [1:0] level;
    logic [1:0] scr_sel;
    logic       game_rst;
    logic       busy;

    screen_seq_ctrl #(
        .LEVELS      (LEVELS),
        .HOLD_FRAMES (HOLD_FRAMES),
        .WIN_FRAMES  (WIN_FRAMES)
    ) dut (
        .pixelclk (pixelclk),
        .reset_n  (reset_n),
        .i_vsync  (i_vsync),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_ok   (btn_ok),
        .btn_back (btn_back),
        .win_i    (win_i),
        .level    (level),
        .scr_sel  (scr_sel),
        .game_rst (game_rst),
        .busy     (busy)
    );

    always #5 pixelclk = ~pixelclk;

    int n_checks   = 0;
    int n_errors   = 0;
    int cyc        = 0;
    int grst_seen  = 0;
    int grst_mark  = 0;

    // Reference model: which screen the player is on and how many frames remain
    typedef enum int {M_TITLE, M_ENTER, M_GAME, M_CLEARED, M_LEAVE} mode_t;
    mode_t m_mode = M_TITLE;
    int    m_sel  = 0;
    int    m_left = 0;
    int    exp_scr = 0;
    int    exp_lvl = 0;
    bit    exp_grst = 1'b0;
    bit    pv = 1'b0, pu = 1'b0, pd = 1'b0, po = 1'b0, pb = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int code_of(input mode_t m);
        case (m)
            M_TITLE:   return 0;
            M_GAME:    return 1;
            M_CLEARED: return 2;
            default:   return 3;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = M_TITLE; m_sel = 0; m_left = 0;
        exp_scr = 0; exp_lvl = 0; exp_grst = 1'b0;
        pv = 1'b0; pu = 1'b0; pd = 1'b0; po = 1'b0; pb = 1'b0;
    endtask

    // Advance the model by one clock using the inputs present at the edge
    task automatic model_step();
        bit fs, ue, de, oe, be;
        if (!reset_n) begin
            model_reset();
            return;
        end
        fs = pv && !i_vsync;
        ue = btn_up && !pu;
        de = btn_down && !pd;
        oe = btn_ok && !po;
        be = btn_back && !pb;
        pv = i_vsync; pu = btn_up; pd = btn_down; po = btn_ok; pb = btn_back;
        exp_grst = 1'b0;
        if (fs) begin
            exp_scr = code_of(m_mode);
            exp_lvl = m_sel;
        end
        case (m_mode)
            M_TITLE: begin
                if (oe) begin
                    m_mode = M_ENTER; m_left = HOLD_FRAMES;
                end else if (ue && !de) begin
                    m_sel = (m_sel + 1) % LEVELS;
                end else if (de && !ue) begin
                    m_sel = (m_sel + LEVELS - 1) % LEVELS;
                end
            end
            M_ENTER: begin
                if (fs) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = M_GAME; exp_grst = 1'b1;
                    end
                end
            end
            M_GAME: begin
                if (win_i) begin
                    m_mode = M_CLEARED; m_left = WIN_FRAMES;
                end else if (be) begin
                    m_mode = M_LEAVE; m_left = HOLD_FRAMES;
                end
            end
            M_CLEARED: begin
                if (fs) m_left--;
                if (oe || m_left == 0) begin
                    if (m_sel + 1 < LEVELS) begin
                        m_sel++; m_mode = M_ENTER;
                    end else begin
                        m_sel = 0; m_mode = M_LEAVE;
                    end
                    m_left = HOLD_FRAMES;
                end
            end
            default: begin
                if (fs) begin
                    m_left--;
                    if (m_left == 0) m_mode = M_TITLE;
                end
            end
        endcase
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge
    task automatic tick();
        @(posedge pixelclk);
        model_step();
        @(negedge pixelclk);
        check("scr_sel", 32'(scr_sel), 32'(exp_scr));
        check("level", 32'(level), 32'(exp_lvl));
        check("game_rst", 32'(game_rst), 32'(exp_grst));
        check("busy", 32'(busy), 32'(m_mode == M_ENTER || m_mode == M_LEAVE));
        if (game_rst === 1'b1) grst_seen++;
        cyc++;
        i_vsync = (cyc % FRAME_CYC) < VIS_CYC;
    endtask

    task automatic run_frames(input int n);
        repeat (n * FRAME_CYC) tick();
    endtask

    // 0 up, 1 down, 2 ok, 3 back: held two cycles, released two cycles
    task automatic press(input int which);
        case (which)
            0: btn_up = 1'b1;
            1: btn_down = 1'b1;
            2: btn_ok = 1'b1;
            default: btn_back = 1'b1;
        endcase
        tick(); tick();
        btn_up = 1'b0; btn_down = 1'b0; btn_ok = 1'b0; btn_back = 1'b0;
        tick(); tick();
    endtask

    task automatic pulse_win();
        win_i = 1'b1;
        tick();
        win_i = 1'b0;
    endtask

    initial begin
        // Reset and idle frames
        repeat (5) tick();
        reset_n = 1'b1;
        run_frames(3);
        check("idle_grst", 32'(grst_seen), 32'd0);
        check("idle_scr", 32'(scr_sel), 32'd0);

        // Level select wrap-around: 1,2,0,1 then 0,2
        repeat (4) press(0);
        repeat (2) press(1);
        run_frames(2);
        check("sel_level", 32'(level), 32'd2);

        // Back to 0, then up together with ok: ok wins, level stays 0
        press(0);
        grst_mark = grst_seen;
        btn_up = 1'b1; btn_ok = 1'b1;
        tick(); tick();
        btn_up = 1'b0; btn_ok = 1'b0;
        run_frames(HOLD_FRAMES + 2);
        check("enter_grst", 32'(grst_seen - grst_mark), 32'd1);
        check("enter_scr", 32'(scr_sel), 32'd1);
        check("enter_lvl", 32'(level), 32'd0);

        // Win level 0, auto-advance to level 1
        pulse_win();
        run_frames(WIN_FRAMES + HOLD_FRAMES + 2);
        check("adv_scr", 32'(scr_sel), 32'd1);
        check("adv_lvl", 32'(level), 32'd1);
        check("adv_grst", 32'(grst_seen - grst_mark), 32'd2);

        // win and back together: win screen, not fade-out
        win_i = 1'b1; btn_back = 1'b1;
        tick();
        win_i = 1'b0;
        tick();
        btn_back = 1'b0;
        check("winback_busy", 32'(busy), 32'd0);
        run_frames(1);
        check("winback_scr", 32'(scr_sel), 32'd2);
        run_frames(WIN_FRAMES + HOLD_FRAMES + 1);
        check("lvl2_lvl", 32'(level), 32'd2);
        check("lvl2_scr", 32'(scr_sel), 32'd1);

        // Last level: skip win with ok, fade out to start
        pulse_win();
        run_frames(5);
        press(2);
        check("skip_busy", 32'(busy), 32'd1);
        run_frames(HOLD_FRAMES + 2);
        check("end_scr", 32'(scr_sel), 32'd0);
        check("end_lvl", 32'(level), 32'd0);
        check("end_busy", 32'(busy), 32'd0);

        // Reset in the middle of a fade-in
        press(2);
        run_frames(12);
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        check("arst_scr", 32'(scr_sel), 32'd0);
        check("arst_lvl", 32'(level), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_grst", 32'(game_rst), 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        grst_mark = grst_seen;
        run_frames(3);
        check("post_rst_grst", 32'(grst_seen - grst_mark), 32'd0);
        check("post_rst_scr", 32'(scr_sel), 32'd0);

        // Random button traffic
        repeat (6000) begin
            if ($urandom_range(11) == 0) btn_up   = ~btn_up;
            if ($urandom_range(11) == 0) btn_down = ~btn_down;
            if ($urandom_range(15) == 0) btn_ok   = ~btn_ok;
            if ($urandom_range(39) == 0) btn_back = ~btn_back;
            win_i = ($urandom_range(149) == 0);
            tick();
        end
        win_i = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; btn_ok = 1'b0; btn_back = 1'b0;
        run_frames(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
